// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: round-robin owner of the seven-segment display with hold time, value latch and digit scan
module seg_disp_arbiter #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int HOLD_CYCLES  = 5000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic [1:0]  mode0,
  input  logic        req1,
  input  logic [31:0] data1,
  input  logic [1:0]  mode1,
  output logic [1:0]  gnt,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] disp_num,
  output logic [1:0]  disp_sw,
  output logic [1:0]  Scanning,
  output logic        blank
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [HW-1:0] H_LOAD  = HW'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t        state, state_n;
  logic [PW-1:0] prescaler;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          rr_last, rr_n, ack0_n, ack1_n, grant0, grant1, expired;
  logic [31:0]   num_n;
  logic [1:0]    sw_n, gnt_n;
  assign expired = hold_cnt == '0;
  assign blank   = prescaler < P_BLANK;
  // arbitration state and latched display registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rr_last  <= 1'b1;
      gnt      <= 2'b00;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      disp_num <= '0;
      disp_sw  <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      rr_last  <= rr_n;
      gnt      <= gnt_n;
      ack0     <= ack0_n;
      ack1     <= ack1_n;
      disp_num <= num_n;
      disp_sw  <= sw_n;
    end
  end
  // next owner, hold countdown, live tracking and grant action
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    rr_n    = rr_last;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    num_n   = disp_num;
    sw_n    = disp_sw;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state)
      IDLE: begin
        grant0 = req0 & (~req1 | rr_last);
        grant1 = req1 & (~req0 | ~rr_last);
      end
      OWN0: begin
        if (!expired) hold_n = hold_cnt - 1'b1;
        if (expired && req1) grant1 = 1'b1;
        else if (expired && !req0) state_n = IDLE;
        else if (req0) begin
          num_n = data0;
          sw_n  = mode0;
        end
      end
      OWN1: begin
        if (!expired) hold_n = hold_cnt - 1'b1;
        if (expired && req0) grant0 = 1'b1;
        else if (expired && !req1) state_n = IDLE;
        else if (req1) begin
          num_n = data1;
          sw_n  = mode1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (grant0) begin
      state_n = OWN0;
      ack0_n  = 1'b1;
      num_n   = data0;
      sw_n    = mode0;
      hold_n  = H_LOAD;
      rr_n    = 1'b0;
    end
    if (grant1) begin
      state_n = OWN1;
      ack1_n  = 1'b1;
      num_n   = data1;
      sw_n    = mode1;
      hold_n  = H_LOAD;
      rr_n    = 1'b1;
    end
    gnt_n = {state_n == OWN1, state_n == OWN0};
  end
  // free-running digit scan, independent of arbitration
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prescaler <= '0;
      Scanning  <= 2'd0;
    end else begin
      prescaler <= (prescaler == P_LAST) ? '0 : prescaler + 1'b1;
      if (prescaler == P_LAST) Scanning <= Scanning + 2'd1;
    end
  end
endmodule
